// File: rtl/riscv_pkg.sv
// Shared fetch-path types and constants for the riscv front end.
package riscv_pkg;

  localparam int XLEN    = 32;
  localparam int INSTR_W = 32;

  localparam logic [INSTR_W-1:0] INSTR_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry queue of fetched {pc, instr} pairs; flush beats push and pop.
// The head is held in its own register so the outputs keep their last value when empty.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  fetch_entry_t             push_data_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output logic                     valid_o,
  output fetch_entry_t             head_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);
  localparam logic [PW:0] CNT_ONE  = (PW+1)'(1);

  fetch_entry_t   mem_q [DEPTH];
  fetch_entry_t   head_q, head_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PW:0]    count_q, count_d;
  logic           do_push, do_pop;

  assign do_pop  = pop_i && (count_q != '0) && !flush_i;
  assign do_push = push_i && !flush_i && ((count_q != CNT_FULL) || do_pop);

  always_comb begin
    rd_ptr_d = do_pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    wr_ptr_d = do_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else if (do_push && !do_pop) begin
      count_d = count_q + CNT_ONE;
    end else if (!do_push && do_pop) begin
      count_d = count_q - CNT_ONE;
    end
  end

  // Next head comes from the incoming word when the queue is empty after the pop.
  always_comb begin
    head_d = head_q;
    if (!flush_i && (count_d != '0)) begin
      if (do_push && (wr_ptr_q == rd_ptr_d)) head_d = push_data_i;
      else                                   head_d = mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

  assign valid_o = (count_q != '0);
  assign head_o  = head_q;
  assign count_o = count_q;

endmodule

// File: rtl/instr_prefetch_buffer.sv
// Sequential instruction prefetch: credit-limited reads to a 1-cycle imem,
// queued {pc, instr} delivery to the core, and redirect flush/restart.
module instr_prefetch_buffer
  import riscv_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter int              XLEN     = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     redirect_valid,
  input  logic [XLEN-1:0]          redirect_pc,
  output logic                     imem_req,
  output logic [XLEN-1:0]          imem_addr,
  input  logic [31:0]              imem_rdata,
  output logic                     if_valid,
  output logic [31:0]              if_instr,
  output logic [XLEN-1:0]          if_pc,
  input  logic                     if_ready,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int OCC_W = $clog2(DEPTH) + 1;
  localparam logic [OCC_W-1:0] OCC_DEPTH = OCC_W'(DEPTH);

  logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]  inflight_pc_q, inflight_pc_d;
  logic             inflight_q, inflight_d;
  logic [XLEN-1:0]  req_addr;
  logic [OCC_W-1:0] credits_used;
  logic             push, pop;
  fetch_entry_t     push_entry, head;
  logic [1:0]       redirect_pc_unused;

  assign redirect_pc_unused = redirect_pc[1:0];

  assign req_addr     = redirect_valid ? {redirect_pc[XLEN-1:2], 2'b00} : fetch_pc_q;
  assign credits_used = occupancy + OCC_W'(inflight_q);

  // Counting the outstanding read against capacity keeps the queue from overflowing.
  assign imem_req  = !rst && (redirect_valid || (credits_used < OCC_DEPTH));
  assign imem_addr = req_addr;

  // A redirect kills the read returning this cycle and any same-cycle pop.
  assign push       = inflight_q && !redirect_valid;
  assign pop        = if_ready && !redirect_valid;
  assign push_entry = '{pc: inflight_pc_q, instr: imem_rdata};

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_pc_d = inflight_pc_q;
    inflight_d    = imem_req;
    if (imem_req) begin
      fetch_pc_d    = req_addr + XLEN'(4);
      inflight_pc_d = req_addr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      inflight_pc_q <= '0;
      inflight_q    <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_pc_q <= inflight_pc_d;
      inflight_q    <= inflight_d;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .flush_i     (redirect_valid),
    .valid_o     (if_valid),
    .head_o      (head),
    .count_o     (occupancy)
  );

  assign if_instr = head.instr;
  assign if_pc    = head.pc;

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// Directed bench for instr_prefetch_buffer with a 1-cycle imem returning word index.
module tb_instr_prefetch_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'hDEAD_BEEF;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_ready;
  logic [2:0]  occupancy;

  int checks = 0;
  int errors = 0;

  instr_prefetch_buffer #(.DEPTH(4), .XLEN(32), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_ready       (if_ready),
    .occupancy      (occupancy)
  );

  always #5 clk = ~clk;

  // word[i] = i; garbage when not requested
  always @(posedge clk) imem_rdata <= imem_req ? (imem_addr >> 2) : 32'hDEAD_BEEF;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic head(input string tag, input logic [31:0] pc, input logic [31:0] instr);
    check({tag, "_valid"}, {31'b0, if_valid}, 32'd1);
    check({tag, "_pc"}, if_pc, pc);
    check({tag, "_instr"}, if_instr, instr);
  endtask

  task automatic wait_occ3(input string tag);
    for (int n = 0; n < 10; n++) begin
      if (occupancy == 3'd3) break;
      cyc();
    end
    check(tag, {29'b0, occupancy}, 32'd3);
  endtask

  initial begin
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; if_ready = 1'b0;
    #12;
    check("rst_valid", {31'b0, if_valid}, 32'd0);
    check("rst_req", {31'b0, imem_req}, 32'd0);
    check("rst_occ", {29'b0, occupancy}, 32'd0);
    check("rst_instr", if_instr, 32'd0);
    check("rst_pc", if_pc, 32'd0);

    // startup and streaming
    cyc();
    rst = 1'b0; if_ready = 1'b1; #1;
    check("c0_req", {31'b0, imem_req}, 32'd1);
    check("c0_addr", imem_addr, 32'h0);
    check("c0_valid", {31'b0, if_valid}, 32'd0);
    cyc(); #1;
    check("c1_valid", {31'b0, if_valid}, 32'd0);
    check("c1_addr", imem_addr, 32'h4);
    cyc(); #1;
    head("c2", 32'h0, 32'd0);
    for (int i = 1; i <= 5; i++) begin
      cyc(); #1;
      head("stream", 32'(4 * i), 32'(i));
      if (i == 2) check("stream_occ", {29'b0, occupancy}, 32'd1);
    end

    // stall until full
    cyc();
    if_ready = 1'b0; #1;
    for (int i = 0; i < 10; i++) cyc();
    #1;
    check("full_occ", {29'b0, occupancy}, 32'd4);
    check("full_req", {31'b0, imem_req}, 32'd0);
    check("full_addr", imem_addr, 32'd40);
    head("full_head", 32'd24, 32'd6);
    if_ready = 1'b1; #1;
    for (int i = 0; i < 5; i++) begin
      head("drain", 32'(24 + 4 * i), 32'(6 + i));
      cyc(); #1;
    end

    // redirect with three entries queued
    if_ready = 1'b0; #1;
    wait_occ3("rd_occ3");
    head("rd_pre", 32'd44, 32'd11);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0103; #1;
    check("rd_req", {31'b0, imem_req}, 32'd1);
    check("rd_addr", imem_addr, 32'h100);
    cyc();
    redirect_valid = 1'b0; if_ready = 1'b1; #1;
    check("rd_t1_valid", {31'b0, if_valid}, 32'd0);
    check("rd_t1_occ", {29'b0, occupancy}, 32'd0);
    check("rd_t1_hold_pc", if_pc, 32'd44);
    cyc(); #1;
    head("rd_t2", 32'h100, 32'h40);
    cyc(); #1;
    head("rd_t3", 32'h104, 32'h41);

    // back-to-back redirects
    cyc();
    redirect_valid = 1'b1; redirect_pc = 32'h40; #1;
    check("bb_addr0", imem_addr, 32'h40);
    cyc();
    redirect_pc = 32'h80; #1;
    check("bb_addr1", imem_addr, 32'h80);
    cyc();
    redirect_valid = 1'b0; #1;
    check("bb_no40", {31'b0, if_valid}, 32'd0);
    cyc(); #1;
    head("bb_first", 32'h80, 32'h20);
    cyc(); #1;
    head("bb_second", 32'h84, 32'h21);

    // redirect near the top of the address space
    cyc();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8; #1;
    check("wrap_addr", imem_addr, 32'hFFFF_FFF8);
    cyc();
    redirect_valid = 1'b0; #1;
    check("wrap_t1_addr", imem_addr, 32'hFFFF_FFFC);
    cyc(); #1;
    head("wrap_a", 32'hFFFF_FFF8, 32'h3FFF_FFFE);
    cyc(); #1;
    head("wrap_b", 32'hFFFF_FFFC, 32'h3FFF_FFFF);
    cyc(); #1;
    head("wrap_c", 32'h0000_0000, 32'h0);

    // async reset mid-stream
    cyc();
    if_ready = 1'b0; #1;
    wait_occ3("ar_occ3");
    #2;
    rst = 1'b1; #1;
    check("ar_valid", {31'b0, if_valid}, 32'd0);
    check("ar_req", {31'b0, imem_req}, 32'd0);
    check("ar_occ", {29'b0, occupancy}, 32'd0);
    check("ar_pc", if_pc, 32'd0);
    check("ar_instr", if_instr, 32'd0);
    cyc(); cyc();
    rst = 1'b0; if_ready = 1'b1; #1;
    check("ar_rel_addr", imem_addr, 32'h0);
    check("ar_rel_req", {31'b0, imem_req}, 32'd1);
    cyc(); cyc(); #1;
    head("ar_first", 32'h0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_prefetch_buffer.md
Name: instr_prefetch_buffer

Overview:
Sequential instruction fetch stage between instr_memory and the riscv core. It generates word-aligned fetch addresses and issues one read per cycle to a synchronous 1-cycle-latency instruction memory. It queues returned {pc, instr} pairs in a small FIFO and delivers them to the core over a valid/ready handshake. Branch/jump redirects from the core flush the queue and any in-flight read, then restart fetch at the new PC.

Parameters:
DEPTH, 4, FIFO entries; power of two, minimum 2
XLEN, 32, PC/address width
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset; one clock, asynchronous, active-high
redirect_valid  in  1  core requests fetch restart this cycle
redirect_pc  in  XLEN  new fetch PC; bits [1:0] ignored
imem_req  out  1  read strobe to instr memory
imem_addr  out  XLEN  byte address, bits [1:0] always 0
imem_rdata  in  32  instruction; valid the cycle after imem_req
if_valid  out  1  head entry available
if_instr  out  32  head instruction
if_pc  out  XLEN  PC of head instruction
if_ready  in  1  core accepts head this cycle
occupancy  out  $clog2(DEPTH)+1  valid entries in FIFO

Behaviour:
- Reset (async assert, sync release): FIFO empty, fetch_pc=RESET_PC, inflight=0. Outputs: if_valid=0, imem_req=0, occupancy=0, if_instr=0, if_pc=0.
- Credit rule: imem_req=1 iff (occupancy + inflight) < DEPTH, or redirect_valid=1. FIFO can never overflow, including a simultaneous push and pop when full.
- Request: imem_addr=fetch_pc (or {redirect_pc[XLEN-1:2],2'b00} on redirect). On each request, register inflight=1 and inflight_pc=imem_addr. Set fetch_pc=imem_addr+4. Wrap 32'hFFFF_FFFC -> 0 silently.
- Response: in the cycle after a request, push {inflight_pc, imem_rdata} into the FIFO at the clock edge, unless killed by a redirect.
- Pop: a transfer occurs when if_valid && if_ready. Head advances at the edge. if_instr and if_pc are driven from the head, registered storage with no combinational path from imem_rdata.
- Push+pop in the same cycle: occupancy unchanged.
- Redirect (cycle T), which takes priority over everything:
  - FIFO flushed at the edge; a same-cycle pop is ignored.
  - The in-flight response arriving in T is discarded.
  - imem_req=1 in T with the aligned redirect_pc.
  - Data returns in T+1 and is pushed at the end of T+1, so if_valid=1 in T+2.
  - if_valid may still be 1 during T; the core must not rely on that entry.
- Back-to-back redirects: each one kills the previous one's in-flight read. Only the last redirect's stream is delivered.
- Steady state with if_ready=1: throughput is 1 instruction per cycle. Startup latency after reset release is 2 cycles: req in cycle 0, if_valid in cycle 2.
- Empty: if_valid=0, and if_instr/if_pc hold their last values.
- Full with if_ready=0: imem_req=0, fetch_pc held.
- imem_rdata is sampled only in a cycle where inflight=1.

Decomposition:
- Shared package riscv_pkg holds:
  - XLEN
  - INSTR_W=32
  - INSTR_NOP=32'h0000_0013
  - typedef fetch_entry_t {pc, instr}
- Sub-module fetch_fifo: synchronous DEPTH-entry FIFO with push, pop and flush; flush has priority.
- Credit, fetch_pc and inflight logic stay in the top of this block.

Test Plan:
- Reset release, memory word[i]=i, if_ready=1 -> if_valid rises in cycle 2. Stream pc=0,4,8,... with instr=0,1,2,... at one per cycle, with no gaps.
- if_ready=0 for 10 cycles -> occupancy saturates at 4 and imem_req drops to 0. Release -> pcs 0,4,8,12,16 are delivered in order with no loss or duplication.
- Redirect to 32'h0000_0103 while 3 entries are queued -> imem_addr=32'h100 the same cycle, and the old entries plus the in-flight read vanish. Two cycles later if_pc=32'h100, then 32'h104.
- Redirect in two consecutive cycles to 0x40 then 0x80 -> first delivered if_pc=0x80; 0x40 is never delivered.
- Redirect to 32'hFFFF_FFF8 -> delivered pcs FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Assert rst mid-stream with occupancy=3 -> outputs clear immediately, without a clock edge. After release, fetch restarts at RESET_PC.
